// File: rtl/axis_result_sink_pkg.sv
// Shared definitions for the filter-subsystem stream blocks: capture FSM encoding
// and a saturating absolute-value helper.
package axis_result_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    localparam int unsigned ABS_MAX_W = 64;

    // |x| for a w-bit signed value sign-extended to ABS_MAX_W; the most negative code
    // saturates to the largest positive w-bit value.
    function automatic logic [ABS_MAX_W-1:0] sat_abs(input logic signed [ABS_MAX_W-1:0] x,
                                                     input int unsigned w);
        logic [ABS_MAX_W-1:0] mag;
        logic [ABS_MAX_W-1:0] lim;
        lim = (ABS_MAX_W'(1) << (w - 1)) - ABS_MAX_W'(1);
        mag = x[ABS_MAX_W-1] ? ABS_MAX_W'(-x) : ABS_MAX_W'(x);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/axis_result_sink_if.sv
// AXI4-Stream data channel carrying signed result samples.
interface axis_result_sink_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered read port; a write is refused when full even if
// a pop happens in the same cycle.
module axis_sync_fifo #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full_c
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              push, pop;

    assign full_c = (count_q == (ADDR_W+1)'(DEPTH));
    assign push   = wr_en && !full_c;
    assign pop    = rd_en && (count_q != '0);

    // Pointer, occupancy and read-port next state; pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;

endmodule

// File: rtl/axis_result_sink.sv
// Terminates the FIR output stream: captures capture_len samples per start into a FIFO,
// tracks the peak magnitude and exposes the buffered samples on a simple read port.
module axis_result_sink
    import axis_result_sink_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned LEN_W  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                axi_clk,
    input  logic                axi_reset_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    capture_len,
    axis_result_sink_if.slave   s_axis,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic [ADDR_W:0]     fifo_count,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   peak_abs
);

    cap_state_e        state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              busy_q, done_q;
    logic              full_c;
    logic              ready_c;
    logic              accept_c;
    logic [DATA_W-1:0] abs_c;

    // Ready depends on registered state only, never on valid.
    assign ready_c      = (state_q == ST_CAPTURE) && !full_c;
    assign s_axis.ready = ready_c;
    assign accept_c     = s_axis.valid && ready_c;
    assign abs_c        = DATA_W'(sat_abs(ABS_MAX_W'(signed'(s_axis.data)), DATA_W));

    axis_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (axi_clk),
        .rst_n    (axi_reset_n),
        .wr_en    (accept_c),
        .wr_data  (s_axis.data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count),
        .full_c   (full_c)
    );

    // Capture FSM, remaining counter and peak tracker next state.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        peak_d      = peak_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    peak_d = '0;
                    if (capture_len != '0) begin
                        state_d     = ST_CAPTURE;
                        remaining_d = capture_len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (accept_c) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (abs_c > peak_q) begin
                        peak_d = abs_c;
                    end
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            peak_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            peak_q      <= peak_d;
            busy_q      <= (state_d == ST_CAPTURE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign peak_abs = peak_q;

endmodule

// File: tb/tb_axis_result_sink.sv
// Directed bench for axis_result_sink; popped samples are checked against a scoreboard queue.
module tb_axis_result_sink;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              axi_clk;
    logic              axi_reset_n;
    logic              start;
    logic [LEN_W-1:0]  capture_len;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   fifo_count;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] peak_abs;

    axis_result_sink_if #(.DATA_W(DATA_W)) s_axis ();

    axis_result_sink #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .start       (start),
        .capture_len (capture_len),
        .s_axis      (s_axis),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .done        (done),
        .peak_abs    (peak_abs)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every read strobe must match the oldest expected sample.
    always @(negedge axi_clk) begin
        if (rd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got 0x%08h, required no read strobe", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got 0x%08h, required 0x%08h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [LEN_W-1:0] len);
        start       = 1'b1;
        capture_len = len;
        tick();
        start       = 1'b0;
    endtask

    // Presents one sample and waits (bounded) for the handshake.
    task automatic send(input logic [DATA_W-1:0] d);
        bit ok;
        ok = 1'b0;
        s_axis.valid = 1'b1;
        s_axis.data  = d;
        for (int i = 0; i < 100; i++) begin
            if (s_axis.ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        s_axis.valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        axi_reset_n  = 1'b0;
        start        = 1'b0;
        capture_len  = '0;
        rd_en        = 1'b0;
        s_axis.valid = 1'b0;
        s_axis.data  = '0;
        repeat (3) tick();
        @(negedge axi_clk);
        check("rst_ready", 32'(s_axis.ready), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_peak", peak_abs, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        tick();
        axi_reset_n = 1'b1;
        tick();

        // 1: four back-to-back samples, extra sample refused after completion
        pulse_start(16'd4);
        exp_q.push_back(32'd10);
        exp_q.push_back(-32'sd20);
        exp_q.push_back(32'd30);
        exp_q.push_back(-32'sd5);
        send(32'd10);
        send(-32'sd20);
        send(32'd30);
        send(-32'sd5);
        s_axis.valid = 1'b1;
        s_axis.data  = 32'd99;
        @(negedge axi_clk);
        check("t1_ready_after4", 32'(s_axis.ready), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        tick();
        tick();
        s_axis.valid = 1'b0;
        @(negedge axi_clk);
        check("t1_count", 32'(fifo_count), 32'd4);
        check("t1_peak", peak_abs, 32'd30);
        tick();
        pop(4);
        @(negedge axi_clk);
        check("t1_count_empty", 32'(fifo_count), 32'd0);
        tick();
        pop(1);
        @(negedge axi_clk);
        check("t1_empty_rd_valid", 32'(rd_valid), 32'd0);
        check("t1_empty_rd_hold", rd_data, 32'hFFFF_FFFB);
        tick();

        // 2/3: fill to full, pop while held sample is blocked, then complete 20 samples
        pulse_start(16'd20);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'(100 + i));
            send(32'(100 + i));
        end
        s_axis.valid = 1'b1;
        s_axis.data  = 32'd116;
        tick();
        tick();
        @(negedge axi_clk);
        check("t2_full_count", 32'(fifo_count), 32'd16);
        check("t2_full_ready", 32'(s_axis.ready), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        @(negedge axi_clk);
        check("t3_pop_no_write_count", 32'(fifo_count), 32'd15);
        check("t3_ready_reasserts", 32'(s_axis.ready), 32'd1);
        exp_q.push_back(32'd116);
        tick();
        s_axis.valid = 1'b0;
        @(negedge axi_clk);
        check("t2_count_after17", 32'(fifo_count), 32'd16);
        check("t2_not_done_yet", 32'(done), 32'd0);
        tick();
        pop(3);
        for (int i = 117; i < 120; i++) begin
            exp_q.push_back(32'(i));
            send(32'(i));
        end
        @(negedge axi_clk);
        check("t2_done_after20", 32'(done), 32'd1);
        check("t2_count_final", 32'(fifo_count), 32'd16);
        check("t2_peak", peak_abs, 32'd119);
        tick();
        pop(11);
        @(negedge axi_clk);
        check("t4_count_start", 32'(fifo_count), 32'd5);
        tick();

        // 4: concurrent push and pop across the pointer wrap
        pulse_start(16'd8);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(200 + i));
            s_axis.valid = 1'b1;
            s_axis.data  = 32'(200 + i);
            rd_en        = 1'b1;
            tick();
            @(negedge axi_clk);
            check("t4_count_steady", 32'(fifo_count), 32'd5);
        end
        @(posedge axi_clk);
        #1;
        s_axis.valid = 1'b0;
        rd_en        = 1'b0;
        @(negedge axi_clk);
        check("t4_done", 32'(done), 32'd1);
        tick();
        pop(5);
        @(negedge axi_clk);
        check("t4_count_drained", 32'(fifo_count), 32'd0);
        tick();

        // 5: saturating peak, start ignored mid-capture, zero-length capture
        pulse_start(16'd3);
        exp_q.push_back(32'h8000_0000);
        send(32'h8000_0000);
        @(negedge axi_clk);
        check("t5_peak_sat", peak_abs, 32'h7FFF_FFFF);
        check("t5_busy", 32'(busy), 32'd1);
        tick();
        pulse_start(16'd9);
        exp_q.push_back(32'd1);
        exp_q.push_back(-32'sd7);
        send(32'd1);
        send(-32'sd7);
        @(negedge axi_clk);
        check("t5_start_ignored_done", 32'(done), 32'd1);
        check("t5_peak_hold", peak_abs, 32'h7FFF_FFFF);
        tick();
        pulse_start(16'd0);
        @(negedge axi_clk);
        check("t5_len0_done", 32'(done), 32'd1);
        check("t5_len0_busy", 32'(busy), 32'd0);
        check("t5_len0_peak", peak_abs, 32'd0);
        check("t5_len0_count", 32'(fifo_count), 32'd3);
        tick();
        pop(3);

        // 6: asynchronous reset in the middle of a capture
        pulse_start(16'd10);
        for (int i = 0; i < 7; i++) send(32'(300 + i));
        @(negedge axi_clk);
        check("t6_count7", 32'(fifo_count), 32'd7);
        @(posedge axi_clk);
        #3;
        axi_reset_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_ready", 32'(s_axis.ready), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_peak", peak_abs, 32'd0);
        tick();
        tick();
        axi_reset_n = 1'b1;
        tick();
        pop(1);
        @(negedge axi_clk);
        check("t6_rd_valid_after_rst", 32'(rd_valid), 32'd0);
        check("t6_done_after_rst", 32'(done), 32'd0);
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
